// File: rtl/feature_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : feature_accumulator
// Purpose  : Multi-beat, multi-channel partial-product accumulator. Each
//            accepted beat carries MUL_PER_FEATURE signed products per channel.
//            The products are reduced and added into a running sum. The first
//            beat of a feature also adds the per-channel bias. On the last beat
//            the total is optionally ReLU-clamped, saturated to ACC_PRECISION
//            and loaded into a single-entry valid/ready output register.
// Ports    : clk, rst (async, active-high)
//            clear            - synchronous abort of the partial sum
//            relu_en          - ReLU enable, sampled with the last beat
//            in_valid/in_ready/in_last, in_data, bias_in - beat input
//            out_valid/out_ready, out_data, out_sat, out_beats - result output
// Revision : 1.0 - initial release
// ============================================================================
module feature_accumulator #(
    parameter int ACC_PRECISION   = 32,
    parameter int MUL_PER_FEATURE = 4,
    parameter int NUM_CHANNELS    = 2,
    parameter int GUARD_BITS      = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  clear,
    input  logic                                                  relu_en,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic                                                  in_last,
    input  logic [NUM_CHANNELS*MUL_PER_FEATURE*ACC_PRECISION-1:0] in_data,
    input  logic [NUM_CHANNELS*ACC_PRECISION-1:0]                 bias_in,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [NUM_CHANNELS*ACC_PRECISION-1:0]                 out_data,
    output logic [NUM_CHANNELS-1:0]                               out_sat,
    output logic [15:0]                                           out_beats
);

    localparam int c_ACC_W = ACC_PRECISION + GUARD_BITS + $clog2(MUL_PER_FEATURE) + 1;
    localparam int c_EXT_W = c_ACC_W - ACC_PRECISION;

    // Largest / smallest representable result, expressed at accumulator width.
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_EXT_W + 1){1'b0}}, {(ACC_PRECISION - 1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_EXT_W + 1){1'b1}}, {(ACC_PRECISION - 1){1'b0}}};
    localparam logic [ACC_PRECISION-1:0] c_RES_MAX = {1'b0, {(ACC_PRECISION - 1){1'b1}}};
    localparam logic [ACC_PRECISION-1:0] c_RES_MIN = {1'b1, {(ACC_PRECISION - 1){1'b0}}};

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_ACCUM = 1'b1;

    logic [0:0]                          r_state;
    logic [0:0]                          w_state_next;
    logic signed [c_ACC_W-1:0]           r_acc [NUM_CHANNELS];
    logic [15:0]                         r_count;
    logic [15:0]                         w_count_next;
    logic                                w_accept;
    logic                                w_finalise;
    logic signed [c_ACC_W-1:0]           w_beat_sum  [NUM_CHANNELS];
    logic signed [c_ACC_W-1:0]           w_acc_final [NUM_CHANNELS];
    logic [NUM_CHANNELS*ACC_PRECISION-1:0] w_res;
    logic [NUM_CHANNELS-1:0]             w_sat;

    logic                                r_out_valid;
    logic [NUM_CHANNELS*ACC_PRECISION-1:0] r_out_data;
    logic [NUM_CHANNELS-1:0]             r_out_sat;
    logic [15:0]                         r_out_beats;

    // The output register is single-entry: input stalls only while a result
    // is held and not being taken this cycle.
    assign in_ready   = !clear && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_finalise = w_accept && in_last;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sat    = r_out_sat;
    assign out_beats  = r_out_beats;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = c_S_IDLE;
        end else if (w_accept) begin
            w_state_next = in_last ? c_S_IDLE : c_S_ACCUM;
        end
    end

    // ------------------------------------------------------------------
    // Beat reduction, running sum and result clamp
    // ------------------------------------------------------------------
    always_comb begin
        w_res = '0;
        w_sat = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_beat_sum[c] = '0;
            for (int i = 0; i < MUL_PER_FEATURE; i++) begin
                w_beat_sum[c] = w_beat_sum[c] +
                    {{c_EXT_W{in_data[(c*MUL_PER_FEATURE + i)*ACC_PRECISION + ACC_PRECISION - 1]}},
                     in_data[(c*MUL_PER_FEATURE + i)*ACC_PRECISION +: ACC_PRECISION]};
            end

            // The first beat of a feature starts from the bias instead of
            // the (zeroed) running sum.
            if (r_state == c_S_IDLE) begin
                w_acc_final[c] = {{c_EXT_W{bias_in[c*ACC_PRECISION + ACC_PRECISION - 1]}},
                                  bias_in[c*ACC_PRECISION +: ACC_PRECISION]} + w_beat_sum[c];
            end else begin
                w_acc_final[c] = r_acc[c] + w_beat_sum[c];
            end

            // ReLU takes priority, so a clamped negative never reports sat.
            if (relu_en && w_acc_final[c][c_ACC_W-1]) begin
                w_res[c*ACC_PRECISION +: ACC_PRECISION] = '0;
                w_sat[c] = 1'b0;
            end else if (w_acc_final[c] > c_SAT_MAX) begin
                w_res[c*ACC_PRECISION +: ACC_PRECISION] = c_RES_MAX;
                w_sat[c] = 1'b1;
            end else if (w_acc_final[c] < c_SAT_MIN) begin
                w_res[c*ACC_PRECISION +: ACC_PRECISION] = c_RES_MIN;
                w_sat[c] = 1'b1;
            end else begin
                w_res[c*ACC_PRECISION +: ACC_PRECISION] = w_acc_final[c][ACC_PRECISION-1:0];
                w_sat[c] = 1'b0;
            end
        end
    end

    always_comb begin
        if (r_state == c_S_IDLE) begin
            w_count_next = 16'd1;
        end else if (r_count == 16'hFFFF) begin
            w_count_next = r_count;
        end else begin
            w_count_next = r_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
            r_out_beats <= '0;
        end else begin
            // clear blocks acceptance, so it never coincides with a beat.
            if (clear || w_finalise) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_acc[c] <= '0;
                end
                r_count <= '0;
            end else if (w_accept) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_acc[c] <= w_acc_final[c];
                end
                r_count <= w_count_next;
            end

            // A finalise in the handshake cycle reloads the register and
            // keeps out_valid high.
            if (w_finalise) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_sat   <= w_sat;
                r_out_beats <= w_count_next;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_feature_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_accumulator
// Purpose  : Self-checking bench for feature_accumulator (P=32, M=4, C=2).
//            Directed scenarios followed by randomized traffic, compared each
//            cycle against a behavioural model built on 64-bit integer sums.
// Revision : 1.0 - initial release
// ============================================================================
module tb_feature_accumulator;

    localparam int P = 32;
    localparam int M = 4;
    localparam int C = 2;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             relu_en;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [C*M*P-1:0] in_data;
    logic [C*P-1:0]   bias_in;
    logic             out_valid;
    logic             out_ready;
    logic [C*P-1:0]   out_data;
    logic [C-1:0]     out_sat;
    logic [15:0]      out_beats;

    feature_accumulator #(
        .ACC_PRECISION   (P),
        .MUL_PER_FEATURE (M),
        .NUM_CHANNELS    (C),
        .GUARD_BITS      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .bias_in   (bias_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus values
    int prod [C][M];
    int bias [C];

    // Behavioural model state
    longint      m_acc [C];
    int          m_beats;
    bit          m_active;
    bit          exp_valid;
    logic [C*P-1:0] exp_data;
    logic [C-1:0]   exp_sat;
    logic [15:0]    exp_beats;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void clamp(input longint s, input bit relu,
                                  output logic [31:0] r, output bit sat);
        if (relu && s < 0) begin
            r = '0; sat = 1'b0;
        end else if (s > 64'sd2147483647) begin
            r = 32'h7FFFFFFF; sat = 1'b1;
        end else if (s < -64'sd2147483648) begin
            r = 32'h80000000; sat = 1'b1;
        end else begin
            r = s[31:0]; sat = 1'b0;
        end
    endfunction

    task automatic set_ch(input int c, input int a, input int b, input int d, input int e);
        prod[c][0] = a; prod[c][1] = b; prod[c][2] = d; prod[c][3] = e;
    endtask

    task automatic drive(input bit v, input bit last, input bit rdy);
        in_valid = v; in_last = last; out_ready = rdy;
    endtask

    // One clock cycle: apply inputs, check in_ready, advance the model,
    // take the edge, then check the output register.
    task automatic step();
        bit          exp_ready;
        bit          acc_ok;
        longint      s;
        logic [31:0] r;
        bit          sat;
        int          nb;
        for (int c = 0; c < C; c++) begin
            bias_in[c*P +: P] = bias[c];
            for (int i = 0; i < M; i++) in_data[(c*M + i)*P +: P] = prod[c][i];
        end
        #1;
        exp_ready = !clear && (!exp_valid || out_ready);
        chk("in_ready", in_ready, exp_ready);
        acc_ok = in_valid && exp_ready;
        if (exp_valid && out_ready) exp_valid = 1'b0;
        if (clear) begin
            m_active = 1'b0;
        end else if (acc_ok) begin
            nb = m_active ? ((m_beats < 65535) ? m_beats + 1 : 65535) : 1;
            for (int c = 0; c < C; c++) begin
                s = m_active ? m_acc[c] : longint'(bias[c]);
                for (int i = 0; i < M; i++) s += longint'(prod[c][i]);
                m_acc[c] = s;
            end
            m_beats = nb;
            if (in_last) begin
                for (int c = 0; c < C; c++) begin
                    clamp(m_acc[c], relu_en, r, sat);
                    exp_data[c*P +: P] = r;
                    exp_sat[c] = sat;
                end
                exp_beats = 16'(nb);
                exp_valid = 1'b1;
                m_active  = 1'b0;
            end else begin
                m_active = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_data", out_data, exp_data);
            chk("out_sat", out_sat, exp_sat);
            chk("out_beats", out_beats, exp_beats);
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        in_valid = 1'b0; clear = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sat", out_sat, '0);
        chk("rst_out_beats", out_beats, '0);
        exp_valid = 1'b0;
        m_active  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 2000)) - 1000;
            2:       return ($urandom_range(0, 1) == 1) ? 32'sh40000000 : -32'sh40000000;
            default: return int'($urandom_range(0, 100000)) - 50000;
        endcase
    endfunction

    initial begin
        rst = 1'b1; clear = 1'b0; relu_en = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_data = '0; bias_in = '0;
        for (int c = 0; c < C; c++) begin
            bias[c] = 0; m_acc[c] = 0;
            for (int i = 0; i < M; i++) prod[c][i] = 0;
        end
        m_beats = 0; m_active = 1'b0; exp_valid = 1'b0;
        exp_data = '0; exp_sat = '0; exp_beats = '0;

        #12;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_sat", out_sat, '0);
        chk("reset_out_beats", out_beats, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat feature with bias
        bias[0] = 10; bias[1] = -5;
        set_ch(0, 1, 2, 3, 4);
        set_ch(1, -1, -1, -1, -1);
        drive(1, 1, 1); step();
        chk("t1_ch0", out_data[31:0], 32'd20);
        chk("t1_ch1", out_data[63:32], 32'hFFFFFFF7);
        chk("t1_beats", out_beats, 16'd1);
        drive(0, 0, 1); step();

        // Three-beat feature, then a back-to-back two-beat feature
        bias[0] = 0; bias[1] = 0;
        set_ch(0, 100, 100, 100, 100);
        set_ch(1, 7, -3, 0, 2);
        drive(1, 0, 1); step();
        step();
        drive(1, 1, 1); step();
        chk("t2_ch0", out_data[31:0], 32'd1200);
        chk("t2_beats", out_beats, 16'd3);
        bias[0] = -50;
        drive(1, 0, 1); step();
        drive(1, 1, 1); step();
        drive(0, 0, 1); step();

        // Positive saturation, negative saturation, ReLU on negative
        bias[0] = 0;
        set_ch(0, 32'sh40000000, 32'sh40000000, 32'sh40000000, 32'sh40000000);
        drive(1, 0, 1); step();
        drive(1, 1, 1); step();
        chk("t3_pos_sat_val", out_data[31:0], 32'h7FFFFFFF);
        chk("t3_pos_sat_flag", out_sat[0], 1'b1);
        set_ch(0, -32'sh40000000, -32'sh40000000, -32'sh40000000, -32'sh40000000);
        drive(1, 0, 1); step();
        drive(1, 1, 1); step();
        chk("t3_neg_sat_val", out_data[31:0], 32'h80000000);
        relu_en = 1'b1;
        drive(1, 0, 1); step();
        drive(1, 1, 1); step();
        chk("t3_relu_val", out_data[31:0], 32'd0);
        chk("t3_relu_flag", out_sat[0], 1'b0);
        relu_en = 1'b0;

        // Stalled output: pending result blocks the next last beat
        set_ch(0, 1, 1, 1, 1);
        drive(1, 1, 0); step();
        set_ch(0, 9, 9, 9, 9);
        drive(1, 1, 0); step();
        step();
        drive(1, 1, 1); step();
        chk("t4_new_result", out_data[31:0], 32'd36);
        drive(0, 0, 1); step();

        // Abort with clear, then a fresh feature
        set_ch(0, 1000, 1000, 1000, 1000);
        drive(1, 0, 1); step();
        step();
        clear = 1'b1; step();
        clear = 1'b0;
        set_ch(0, 5, 5, 5, 5);
        drive(1, 1, 1); step();
        chk("t5_after_clear", out_data[31:0], 32'd20);
        drive(0, 0, 1); step();

        // Async reset with a pending result, then with a partial sum
        drive(1, 1, 0); step();
        async_reset();
        set_ch(0, 3, 4, 5, 6);
        drive(1, 1, 1); step();
        set_ch(0, 500, 500, 500, 500);
        drive(1, 0, 1); step();
        step();
        async_reset();
        set_ch(0, 3, 4, 5, 6);
        drive(1, 1, 1); step();
        chk("t6_after_reset", out_data[31:0], 32'd18);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < C; c++) begin
                bias[c] = rnd_val();
                for (int i = 0; i < M; i++) prod[c][i] = rnd_val();
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 9) < 3);
            out_ready = ($urandom_range(0, 9) < 7);
            relu_en   = ($urandom_range(0, 1) == 1);
            clear     = ($urandom_range(0, 99) < 3);
            step();
        end
        clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
